instruction_fetch: RTL

IF stage of the 64-bit LEGv8 pipeline.
- Owns the PC, issues word fetches to instruction memory over a req/ack handshake, and presents {PC, instruction} to decode.
- Consumes the branch outcome (PCSrc, branch target) that the execute/memory stages send back, redirecting the PC and squashing any wrong-path fetch in flight.

---
 rtl/instruction_fetch_pkg.sv | 26 ++
 rtl/instruction_fetch_pc_reg.sv | 43 ++++
 rtl/instruction_fetch.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared pipeline definitions for the LEGv8 instruction fetch stage:
// fetch FSM encoding, datapath widths and small PC/counter helpers.
package instruction_fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 64;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_REQ  = 2'b00,
        ST_WAIT = 2'b01,
        ST_HOLD = 2'b10
    } fetch_state_t;

    // Instruction fetches are always word aligned; low address bits are dropped.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

    function automatic logic [31:0] sat_add32(input logic [31:0] value, input logic [1:0] inc);
        logic [32:0] sum;
        sum = {1'b0, value} + {31'd0, inc};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/instruction_fetch_pc_reg.sv
// Program counter of the fetch stage: PC register, sequential adder and
// redirect mux, with a redirect taking priority over sequential advance.
module if_pc_reg
    import instruction_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 64'h0,
    parameter int                PC_STEP  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pc_src,
    input  logic              advance,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_next_s;

    // Next-PC selection: redirect, then sequential step, else hold.
    always_comb begin
        pc_next_s = pc_r;
        if (pc_src) begin
            pc_next_s = word_align(branch_target);
        end else if (advance) begin
            pc_next_s = pc_r + 64'(PC_STEP);
        end else begin
            pc_next_s = pc_r;
        end
    end

    // PC register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= pc_next_s;
        end
    end

    assign pc = pc_r;

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: req/ack fetch FSM, decode-side output register and redirect squash.
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 64'h0,
    parameter int                PC_STEP  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pc_src,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic               stall,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    output logic [ADDR_W-1:0]  if_pc,
    output logic [INSTR_W-1:0] if_instr
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]        fetch_count,
    output logic [31:0]        squash_count
`endif
);

    fetch_state_t       state_r;
    logic               squash_r;
    logic               imem_req_r;
    logic [ADDR_W-1:0]  imem_addr_r;
    logic               if_valid_r;
    logic [ADDR_W-1:0]  if_pc_r;
    logic [INSTR_W-1:0] if_instr_r;
    logic [ADDR_W-1:0]  pc_s;
    logic               advance_s;

    // A fetch retires (and the PC steps) only on an ack that is neither
    // stale from an earlier redirect nor overtaken by one this cycle.
    always_comb begin
        advance_s = 1'b0;
        if ((state_r == ST_WAIT) && imem_ack && !squash_r && !pc_src) begin
            advance_s = 1'b1;
        end else begin
            advance_s = 1'b0;
        end
    end

    if_pc_reg #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_reg (
        .clk           (clk),
        .reset         (reset),
        .pc_src        (pc_src),
        .advance       (advance_s),
        .branch_target (branch_target),
        .pc            (pc_s)
    );

    // Fetch FSM with registered memory request and decode outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_REQ;
            squash_r    <= 1'b0;
            imem_req_r  <= 1'b0;
            imem_addr_r <= RESET_PC;
            if_valid_r  <= 1'b0;
            if_pc_r     <= 64'h0;
            if_instr_r  <= NOP_INSTR;
        end else begin
            if (if_valid_r && !stall) begin
                if_valid_r <= 1'b0;
            end
            if (pc_src) begin
                if_valid_r <= 1'b0;
                case (state_r)
                    ST_WAIT: begin
                        if (imem_ack) begin
                            squash_r   <= 1'b0;
                            imem_req_r <= 1'b0;
                            state_r    <= ST_REQ;
                        end else begin
                            // Request stays on the bus; its data is dropped later.
                            squash_r   <= 1'b1;
                            state_r    <= ST_WAIT;
                        end
                    end
                    default: begin
                        imem_req_r <= 1'b0;
                        state_r    <= ST_REQ;
                    end
                endcase
            end else begin
                case (state_r)
                    ST_REQ: begin
                        imem_req_r  <= 1'b1;
                        imem_addr_r <= pc_s;
                        state_r     <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (imem_ack) begin
                            imem_req_r <= 1'b0;
                            if (squash_r) begin
                                squash_r <= 1'b0;
                                state_r  <= ST_REQ;
                            end else begin
                                if_valid_r <= 1'b1;
                                if_pc_r    <= pc_s;
                                if_instr_r <= imem_rdata;
                                state_r    <= stall ? ST_HOLD : ST_REQ;
                            end
                        end
                    end
                    ST_HOLD: begin
                        imem_req_r <= 1'b0;
                        if (!stall) begin
                            state_r <= ST_REQ;
                        end
                    end
                    default: begin
                        imem_req_r <= 1'b0;
                        squash_r   <= 1'b0;
                        state_r    <= ST_REQ;
                    end
                endcase
            end
        end
    end

    assign imem_req  = imem_req_r;
    assign imem_addr = imem_addr_r;
    assign if_valid  = if_valid_r;
    assign if_pc     = if_pc_r;
    assign if_instr  = if_instr_r;

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_r;
    logic [31:0] squash_cnt_r;
    logic [1:0]  squash_inc_s;

    // A dropped ack and a squashed presented instruction can coincide.
    always_comb begin
        squash_inc_s = 2'd0;
        if ((state_r == ST_WAIT) && imem_ack && (squash_r || pc_src)) begin
            squash_inc_s = 2'd1;
        end else begin
            squash_inc_s = 2'd0;
        end
        if (pc_src && if_valid_r) begin
            squash_inc_s = squash_inc_s + 2'd1;
        end else begin
            squash_inc_s = squash_inc_s;
        end
    end

    // Saturating fetch/squash event counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_cnt_r  <= 32'd0;
            squash_cnt_r <= 32'd0;
        end else begin
            fetch_cnt_r  <= sat_add32(fetch_cnt_r, {1'b0, advance_s});
            squash_cnt_r <= sat_add32(squash_cnt_r, squash_inc_s);
        end
    end

    assign fetch_count  = fetch_cnt_r;
    assign squash_count = squash_cnt_r;
`endif

endmodule
